// File: rtl/fb_arb_pkg.sv
// Shared encodings and constants for the frame-buffer port arbiter.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_state_t;

  localparam int ADDR_W       = 10;
  localparam int BANK_BIT     = 10;
  localparam int STARVE_LIMIT = 7;

endpackage

// File: rtl/fb_write_fifo.sv
// Small synchronous FIFO holding pending {addr, data} pixel writes.
// Push is ignored when full; pop is ignored when empty.
module fb_write_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; contents are discarded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates one single-port pixel RAM between scan-out reads and buffered
// SPI writes, and owns the double-buffer bank bit.
// Optional macro FB_ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// cycles with the write FIFO full and no pop, one write preempts a read.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int BITS_PER_PIXEL = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [BITS_PER_PIXEL-1:0] wr_data,
  input  logic                      wr_frame_end,
  input  logic                      rd_req,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_grant,
  output logic [BITS_PER_PIXEL-1:0] rd_data,
  output logic                      rd_data_valid,
  input  logic                      rd_frame_start,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W:0]           ram_addr,
  output logic [BITS_PER_PIXEL-1:0] ram_wdata,
  input  logic [BITS_PER_PIXEL-1:0] ram_rdata,
  output logic                      display_bank,
  output logic                      flip_pending
);

  localparam int ENTRY_W = ADDR_W + BITS_PER_PIXEL;

  arb_state_t                arb;
  arb_state_t                last_grant;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [ENTRY_W-1:0]        fifo_head;
  logic [ADDR_W-1:0]         head_addr;
  logic [BITS_PER_PIXEL-1:0] head_data;
  logic                      push;
  logic                      pop;
  logic                      flip;
  logic                      force_write;

  assign wr_ready  = !fifo_full && !flip_pending && !reset;
  assign push      = wr_valid && wr_ready;
  assign head_addr = fifo_head[ENTRY_W-1 -: ADDR_W];
  assign head_data = fifo_head[BITS_PER_PIXEL-1:0];
  assign pop       = (arb == ARB_WRITE);
  assign rd_data   = ram_rdata;
  // RAM read latency is one cycle, so a read granted last cycle returns now.
  assign rd_data_valid = (last_grant == ARB_READ);
  // A flip must not race a pending or in-flight write into the back bank.
  assign flip = rd_frame_start && flip_pending && fifo_empty && !pop;

  fb_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

`ifdef FB_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign force_write = (starve_cnt == 3'(STARVE_LIMIT));

  // Count consecutive full-and-stalled cycles; any pop restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (pop || !fifo_full) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 3'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_write = 1'b0;
`endif

  // Per-cycle arbitration: reads win unless the starvation guard fires.
  always_comb begin
    arb       = ARB_IDLE;
    rd_grant  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (reset)                         arb = ARB_IDLE;
    else if (force_write && !fifo_empty) arb = ARB_WRITE;
    else if (rd_req)                   arb = ARB_READ;
    else if (!fifo_empty)              arb = ARB_WRITE;
    case (arb)
      ARB_READ: begin
        rd_grant = 1'b1;
        ram_en   = 1'b1;
        ram_addr = {display_bank, rd_addr};
      end
      ARB_WRITE: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {~display_bank, head_addr};
        ram_wdata = head_data;
      end
      default: ;
    endcase
  end

  // Grant history, bank ownership and frame-commit flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant   <= ARB_IDLE;
      display_bank <= 1'b0;
      flip_pending <= 1'b0;
    end else begin
      last_grant <= arb;
      if (flip) begin
        display_bank <= ~display_bank;
        flip_pending <= 1'b0;
      end else if (wr_frame_end && !flip_pending) begin
        flip_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed, table-driven bench for fb_port_arbiter plus hand-written
// sequences for the stall, deferred-flip and reset corner cases.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_frame_end;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic        rd_grant;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        rd_frame_start;
  logic        ram_en;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        display_bank;
  logic        flip_pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .BITS_PER_PIXEL (16),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_frame_end   (wr_frame_end),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_grant       (rd_grant),
    .rd_data        (rd_data),
    .rd_data_valid  (rd_data_valid),
    .rd_frame_start (rd_frame_start),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .display_bank   (display_bank),
    .flip_pending   (flip_pending)
  );

  typedef struct {
    logic        wv;
    logic [9:0]  wa;
    logic [15:0] wd;
    logic        wfe;
    logic        rr;
    logic [9:0]  ra;
    logic        rfs;
    logic [15:0] rdat;
    logic        e_wrdy;
    logic        e_grant;
    logic        e_en;
    logic        e_we;
    logic [10:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_rdv;
    logic        e_bank;
    logic        e_fp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic wv, input logic [9:0] wa, input logic [15:0] wd, input logic wfe,
    input logic rr, input logic [9:0] ra, input logic rfs, input logic [15:0] rdat,
    input logic e_wrdy, input logic e_grant, input logic e_en, input logic e_we,
    input logic [10:0] e_addr, input logic [15:0] e_wdata, input logic e_rdv,
    input logic e_bank, input logic e_fp);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.wfe = wfe;
    v.rr = rr; v.ra = ra; v.rfs = rfs; v.rdat = rdat;
    v.e_wrdy = e_wrdy; v.e_grant = e_grant; v.e_en = e_en; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdv = e_rdv;
    v.e_bank = e_bank; v.e_fp = e_fp;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [9:0] wa, input logic [15:0] wd,
                       input logic wfe, input logic rr, input logic [9:0] ra,
                       input logic rfs);
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_frame_end = wfe;
    rd_req = rr; rd_addr = ra; rd_frame_start = rfs;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    ram_rdata = 16'h0;

    //   wv  wa      wd       wfe rr ra      rfs rdat    | wrdy gnt en we addr     wdata    rdv bank fp
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 0, 10'h000, 0, 16'h0000, 1, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 10'h005, 16'hABCD, 0, 0, 10'h000, 0, 16'h0000, 1, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 0, 10'h000, 0, 16'h0000, 1, 0, 1, 1, 11'h405, 16'hABCD, 0, 0, 0));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 1, 10'h010, 0, 16'h1234, 1, 1, 1, 0, 11'h010, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 0, 10'h000, 0, 16'h1234, 1, 0, 0, 0, 11'h000, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 1, 0, 10'h000, 0, 16'h0000, 1, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 0, 10'h000, 0, 16'h0000, 0, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 0, 10'h000, 1, 16'h0000, 0, 0, 0, 0, 11'h000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 0, 10'h000, 0, 16'h0000, 1, 0, 0, 0, 11'h000, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(1, 10'h3FF, 16'h5A5A, 0, 0, 10'h000, 0, 16'h0000, 1, 0, 0, 0, 11'h000, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 0, 10'h000, 0, 16'h0000, 1, 0, 1, 1, 11'h3FF, 16'h5A5A, 0, 1, 0));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 1, 10'h020, 0, 16'h0000, 1, 1, 1, 0, 11'h420, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 10'h000, 16'h0000, 0, 0, 10'h000, 0, 16'h0000, 1, 0, 0, 0, 11'h000, 16'h0000, 1, 1, 0));

    // Reset held: outputs quiescent even with a read request present.
    rd_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", 0, wr_ready, 0);
    chk("rst_rd_grant", 0, rd_grant, 0);
    chk("rst_ram_en",   0, ram_en,   0);
    rd_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Table-driven vectors, one per clock.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].wfe, tbl[i].rr, tbl[i].ra, tbl[i].rfs);
      ram_rdata = tbl[i].rdat;
      @(negedge clk);
      chk("wr_ready",      i, wr_ready,      tbl[i].e_wrdy);
      chk("rd_grant",      i, rd_grant,      tbl[i].e_grant);
      chk("ram_en",        i, ram_en,        tbl[i].e_en);
      chk("ram_we",        i, ram_we,        tbl[i].e_we);
      if (tbl[i].e_en)  chk("ram_addr",  i, ram_addr,  tbl[i].e_addr);
      if (tbl[i].e_we)  chk("ram_wdata", i, ram_wdata, tbl[i].e_wdata);
      chk("rd_data_valid", i, rd_data_valid, tbl[i].e_rdv);
      chk("rd_data",       i, rd_data,       tbl[i].rdat);
      chk("display_bank",  i, display_bank,  tbl[i].e_bank);
      chk("flip_pending",  i, flip_pending,  tbl[i].e_fp);
      next_cycle();
    end

`ifndef FB_ARB_STARVE_GUARD_EN
    // Continuous reads starve the writer: FIFO fills, no write reaches RAM.
    // Display bank is 1 here, so reads go to 0x410 and writes to bank 0.
    for (int i = 0; i < 16; i++) begin
      drive(i < 5, 10'(10'h100 + i), 16'(16'h1000 + i), 0, 1, 10'h010, 0);
      @(negedge clk);
      chk("stall_we",    i, ram_we,        0);
      chk("stall_grant", i, rd_grant,      1);
      chk("stall_addr",  i, ram_addr,      11'h410);
      chk("stall_ready", i, wr_ready,      (i < 4));
      chk("stall_rdv",   i, rd_data_valid, (i >= 1));
      next_cycle();
    end
    // Reads released: the four queued words drain in order.
    for (int j = 0; j < 5; j++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("drain_we", j, ram_we, (j < 4));
      if (j < 4) begin
        chk("drain_addr",  j, ram_addr,  11'(11'h100 + j));
        chk("drain_wdata", j, ram_wdata, 16'(16'h1000 + j));
      end
      next_cycle();
    end
`endif

    // Deferred flip: FIFO non-empty under continuous reads at frame start.
    drive(1, 10'h050, 16'hB0B0, 0, 1, 10'h030, 0);
    next_cycle();
    drive(1, 10'h051, 16'hB1B1, 1, 1, 10'h030, 0);
    @(negedge clk);
    chk("defer_ready", 0, wr_ready, 1);
    next_cycle();
    drive(0, 0, 0, 0, 1, 10'h030, 1);
    @(negedge clk);
    chk("defer_fp",    0, flip_pending, 1);
    chk("defer_ready", 1, wr_ready,     0);
    next_cycle();
    drive(0, 0, 0, 0, 1, 10'h030, 0);
    @(negedge clk);
    chk("defer_bank", 0, display_bank, 1);
    chk("defer_fp",   1, flip_pending, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("defer_we",   0, ram_we,   1);
    chk("defer_addr", 0, ram_addr, 11'h050);
    next_cycle();
    @(negedge clk);
    chk("defer_we",   1, ram_we,   1);
    chk("defer_addr", 1, ram_addr, 11'h051);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("defer_en", 0, ram_en, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flip_bank",  0, display_bank, 0);
    chk("flip_fp",    0, flip_pending, 0);
    chk("flip_ready", 0, wr_ready,     1);
    next_cycle();

    // Same-cycle frame end/start, then reset with three words queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 10'(10'h060 + i), 16'(16'hC000 + i), 0, 1, 10'h040, 0);
      next_cycle();
    end
    drive(0, 0, 0, 1, 1, 10'h040, 1);
    next_cycle();
    drive(0, 0, 0, 0, 1, 10'h040, 0);
    @(negedge clk);
    chk("same_fp",   0, flip_pending, 1);
    chk("same_bank", 0, display_bank, 0);
    #1 reset = 1'b1;
    #1;
    chk("midrst_ready", 0, wr_ready, 0);
    chk("midrst_grant", 0, rd_grant, 0);
    chk("midrst_en",    0, ram_en,   0);
    chk("midrst_fp",    0, flip_pending, 0);
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_en",    0, ram_en,        0);
    chk("post_rst_fp",    0, flip_pending,  0);
    chk("post_rst_bank",  0, display_bank,  0);
    chk("post_rst_rdv",   0, rd_data_valid, 0);
    chk("post_rst_ready", 0, wr_ready,      1);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
